// File: rtl/word_ser_pkg.sv
// word_ser_pkg
// Shared definitions for the word-to-byte serializer:
//   ser_state_t - two-state control FSM encoding (IDLE / SHIFT)
//   BYTE_W      - width of one emitted beat
//   start_idx() - first byte index presented for a new word
package word_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int BYTE_W = 8;

  // LSB-first starts at byte 0; MSB-first starts at the top byte and
  // walks downwards, so partial words take the upper bytes.
  function automatic int start_idx(input bit msb_first, input int nbytes);
    return msb_first ? (nbytes - 1) : 0;
  endfunction

endpackage

// File: rtl/word_byte_mux.sv
// word_byte_mux
// Combinational byte select from a held word.
// Ports:
//   word_in  [BYTE_W*NBYTES-1:0] - held word
//   idx_in   [$clog2(NBYTES)-1:0] - byte lane to present
//   byte_out [BYTE_W-1:0]         - selected byte
module word_byte_mux
  import word_ser_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic [BYTE_W*NBYTES-1:0]  word_in,
  input  logic [$clog2(NBYTES)-1:0] idx_in,
  output logic [BYTE_W-1:0]         byte_out
);

  localparam int IW = $clog2(NBYTES);

  logic [BYTE_W-1:0] lanes [NBYTES];

  // Split the word into byte lanes once so the select below stays readable.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign lanes[gi] = word_in[BYTE_W*gi +: BYTE_W];
  end

  // Case-style select; any index not matched falls back to the top byte.
  always_comb begin
    byte_out = lanes[NBYTES-1];
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_in == IW'(i)) begin
        byte_out = lanes[i];
      end
    end
  end

endmodule

// File: rtl/word_byte_serializer.sv
// word_byte_serializer
// Accepts NBYTES-wide words on a valid/ready channel and emits them one byte
// per beat on a second valid/ready channel. Partial words (in_nbytes+1 bytes)
// and a per-word end-of-packet flag are supported.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - input word handshake
//   in_data              - word to serialize
//   in_nbytes            - valid bytes minus one
//   in_last              - word ends a packet
//   out_valid/out_ready  - output byte handshake
//   out_byte             - presented byte
//   out_last             - final byte of a packet-ending word
//   out_idx              - byte index presented (drives the byte mux)
//   busy                 - a word is held
module word_byte_serializer
  import word_ser_pkg::*;
#(
  parameter int NBYTES    = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W*NBYTES-1:0]  in_data,
  input  logic [$clog2(NBYTES)-1:0] in_nbytes,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTE_W-1:0]         out_byte,
  output logic                      out_last,
  output logic [$clog2(NBYTES)-1:0] out_idx,
  output logic                      busy
);

  localparam int            IW    = $clog2(NBYTES);
  localparam int            DW    = BYTE_W * NBYTES;
  localparam logic [IW-1:0] START = IW'(start_idx(MSB_FIRST, NBYTES));
  localparam logic [IW-1:0] ONE   = IW'(1);

  ser_state_t    state_q,  state_d;
  logic [DW-1:0] word_q,   word_d;
  logic [IW-1:0] nbytes_q, nbytes_d;
  logic          last_q,   last_d;
  logic [IW-1:0] cnt_q,    cnt_d;
  logic [IW-1:0] idx_q,    idx_d;

  logic final_beat;
  logic capture;

  // The terminal check uses the count before it steps, so neither counter
  // ever wraps inside a word.
  assign final_beat = (cnt_q == nbytes_q);

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    nbytes_d = nbytes_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    in_ready = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        if (out_ready) begin
          if (final_beat) begin
            // Freeing the word register in the same cycle lets the next
            // word follow with no bubble; this is why in_ready sees
            // out_ready combinationally.
            in_ready = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
            idx_d    = START;
          end else begin
            cnt_d = cnt_q + ONE;
            idx_d = MSB_FIRST ? (idx_q - ONE) : (idx_q + ONE);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    capture = in_ready & in_valid;
    if (capture) begin
      state_d  = SHIFT;
      word_d   = in_data;
      nbytes_d = in_nbytes;
      last_d   = in_last;
      cnt_d    = '0;
      idx_d    = START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      nbytes_q <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= START;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      nbytes_q <= nbytes_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

  assign out_valid = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT);
  assign out_last  = out_valid & last_q & final_beat;
  assign out_idx   = idx_q;

  word_byte_mux #(
    .NBYTES (NBYTES)
  ) u_mux (
    .word_in  (word_q),
    .idx_in   (idx_q),
    .byte_out (out_byte)
  );

endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench: two serializer instances (LSB-first and MSB-first) share
// the same input stimulus; each step is followed by hand-computed checks.
module tb_word_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_nbytes;
  logic        in_last;
  logic        out_ready;

  logic       l_in_ready, l_out_valid, l_out_last, l_busy;
  logic [7:0] l_out_byte;
  logic [1:0] l_out_idx;
  logic       m_in_ready, m_out_valid, m_out_last, m_busy;
  logic [7:0] m_out_byte;
  logic [1:0] m_out_idx;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  word_byte_serializer #(.NBYTES(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_data(in_data), .in_nbytes(in_nbytes), .in_last(in_last),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_byte(l_out_byte),
    .out_last(l_out_last), .out_idx(l_out_idx), .busy(l_busy)
  );

  word_byte_serializer #(.NBYTES(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .in_nbytes(in_nbytes), .in_last(in_last),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_byte(m_out_byte),
    .out_last(m_out_last), .out_idx(m_out_idx), .busy(m_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // LSB instance: valid, byte, idx, last, in_ready
  task automatic chk_l(input string tag, input logic v, input logic [7:0] b,
                       input logic [1:0] i, input logic l, input logic r);
    chk({tag, ".lsb.valid"}, 32'(l_out_valid), 32'(v));
    if (v) begin
      chk({tag, ".lsb.byte"}, 32'(l_out_byte), 32'(b));
      chk({tag, ".lsb.idx"},  32'(l_out_idx),  32'(i));
      chk({tag, ".lsb.last"}, 32'(l_out_last), 32'(l));
    end
    chk({tag, ".lsb.in_ready"}, 32'(l_in_ready), 32'(r));
    $display("step %-10s lsb v=%b byte=%h idx=%0d last=%b in_ready=%b busy=%b",
             tag, l_out_valid, l_out_byte, l_out_idx, l_out_last, l_in_ready, l_busy);
  endtask

  task automatic chk_m(input string tag, input logic v, input logic [7:0] b,
                       input logic [1:0] i, input logic l);
    chk({tag, ".msb.valid"}, 32'(m_out_valid), 32'(v));
    if (v) begin
      chk({tag, ".msb.byte"}, 32'(m_out_byte), 32'(b));
      chk({tag, ".msb.idx"},  32'(m_out_idx),  32'(i));
      chk({tag, ".msb.last"}, 32'(m_out_last), 32'(l));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_nbytes = '0;
    in_last = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk_l("reset", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    chk("reset.lsb.busy", 32'(l_busy), 32'd0);
    chk("reset.lsb.idx", 32'(l_out_idx), 32'd0);
    chk("reset.lsb.last", 32'(l_out_last), 32'd0);
    chk("reset.msb.idx", 32'(m_out_idx), 32'd3);
    chk("reset.msb.busy", 32'(m_busy), 32'd0);

    // Full word, packet end
    in_valid = 1'b1; in_data = 32'hAABBCCDD; in_nbytes = 2'd3; in_last = 1'b1;
    chk("full.accept", 32'(l_in_ready), 32'd1);
    step(); in_valid = 1'b0;
    chk_l("full0", 1'b1, 8'hDD, 2'd0, 1'b0, 1'b0); chk_m("full0", 1'b1, 8'hAA, 2'd3, 1'b0);
    step();
    chk_l("full1", 1'b1, 8'hCC, 2'd1, 1'b0, 1'b0); chk_m("full1", 1'b1, 8'hBB, 2'd2, 1'b0);
    step();
    chk_l("full2", 1'b1, 8'hBB, 2'd2, 1'b0, 1'b0); chk_m("full2", 1'b1, 8'hCC, 2'd1, 1'b0);
    step();
    chk_l("full3", 1'b1, 8'hAA, 2'd3, 1'b1, 1'b1); chk_m("full3", 1'b1, 8'hDD, 2'd0, 1'b1);
    step();
    chk_l("full.done", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1); chk_m("full.done", 1'b0, 8'h00, 2'd0, 1'b0);
    chk("full.done.busy", 32'(l_busy), 32'd0);

    // Partial word, two bytes, not packet end
    in_valid = 1'b1; in_data = 32'h11223344; in_nbytes = 2'd1; in_last = 1'b0;
    step(); in_valid = 1'b0;
    chk_l("part0", 1'b1, 8'h44, 2'd0, 1'b0, 1'b0); chk_m("part0", 1'b1, 8'h11, 2'd3, 1'b0);
    step();
    chk_l("part1", 1'b1, 8'h33, 2'd1, 1'b0, 1'b1); chk_m("part1", 1'b1, 8'h22, 2'd2, 1'b0);
    step();
    chk_l("part.done", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Back-to-back words with no bubble
    in_valid = 1'b1; in_data = 32'h01020304; in_nbytes = 2'd3; in_last = 1'b0;
    step(); in_data = 32'h05060708;
    chk_l("b2b0", 1'b1, 8'h04, 2'd0, 1'b0, 1'b0); step();
    chk_l("b2b1", 1'b1, 8'h03, 2'd1, 1'b0, 1'b0); step();
    chk_l("b2b2", 1'b1, 8'h02, 2'd2, 1'b0, 1'b0); step();
    chk_l("b2b3", 1'b1, 8'h01, 2'd3, 1'b0, 1'b1); step();
    in_valid = 1'b0;
    chk_l("b2b4", 1'b1, 8'h08, 2'd0, 1'b0, 1'b0); step();
    chk_l("b2b5", 1'b1, 8'h07, 2'd1, 1'b0, 1'b0); step();
    chk_l("b2b6", 1'b1, 8'h06, 2'd2, 1'b0, 1'b0); step();
    chk_l("b2b7", 1'b1, 8'h05, 2'd3, 1'b0, 1'b1); step();
    chk_l("b2b.done", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Backpressure on CC, then reset while BB is presented
    in_valid = 1'b1; in_data = 32'hAABBCCDD; in_nbytes = 2'd3; in_last = 1'b1;
    step(); in_valid = 1'b0; in_data = 32'h99999999;
    chk_l("bp0", 1'b1, 8'hDD, 2'd0, 1'b0, 1'b0); step();
    out_ready = 1'b0;
    chk_l("bp.cc", 1'b1, 8'hCC, 2'd1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_l("bp.stall", 1'b1, 8'hCC, 2'd1, 1'b0, 1'b0);
    end
    out_ready = 1'b1; step();
    chk_l("bp.bb", 1'b1, 8'hBB, 2'd2, 1'b0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk_l("rst.flush", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    chk("rst.flush.busy", 32'(l_busy), 32'd0);
    chk("rst.flush.idx", 32'(l_out_idx), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_l("rst.quiet", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
